// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared UART constants and state encoding (tx and rx)      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_DEF_CLK_FREQ = 50_000_000;
  localparam int UART_DEF_BAUD     = 115_200;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] i_d);
    return ^i_d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_baud_gen : per-bit down-counter, one-cycle o_bit_done pulse     |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_bit_done
);

  localparam int                C_CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [C_CNT_W-1:0] C_RELOAD = C_CNT_W'(CLKS_PER_BIT - 1);

  logic [C_CNT_W-1:0] r_cnt;
  logic               w_expire;

  assign w_expire   = i_en && (r_cnt == '0);
  assign o_bit_done = w_expire && !i_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || w_expire) begin
      r_cnt <= C_RELOAD;
    end else if (i_en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx  : byte-wide UART transmitter, 8N1 (8E1 with                 |
// |            UART_TX_PARITY_EN defined), valid/ready byte input        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = UART_DEF_CLK_FREQ,
  parameter int BAUD     = UART_DEF_BAUD
) (
  input  logic       FPGA_CLK,
  input  logic       RST_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       UART_TXD,
  output logic       TX_BUSY
);

  localparam int         C_CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [2:0] C_LAST_BIT     = 3'(UART_DATA_BITS - 1);

  generate
    if (C_CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ / BAUD must be at least 2");
    end
  endgenerate

  uart_state_e r_state;
  uart_state_e w_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_idx_next;
  logic        r_txd;
  logic        r_ready;
  logic        r_busy;
  logic        w_txd_next;
  logic        w_accept;
  logic        w_bit_done;

  // r_ready mirrors "state is IDLE", so it doubles as the internal accept gate
  assign w_accept = TX_VALID && r_ready;

  uart_baud_gen #(
    .CLKS_PER_BIT(C_CLKS_PER_BIT)
  ) u_baud_gen (
    .clk       (FPGA_CLK),
    .rst_n     (RST_N),
    .i_clear   (w_accept),
    .i_en      (r_state != UART_IDLE),
    .o_bit_done(w_bit_done)
  );

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= even_parity(TX_DATA);
    end
  end
`endif

  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= UART_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_txd     <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_txd     <= w_txd_next;
      r_ready   <= (w_next == UART_IDLE);
      r_busy    <= (w_next != UART_IDLE);
    end
  end

  always_comb begin
    w_next         = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    case (r_state)
      UART_IDLE: begin
        if (w_accept) begin
          w_next         = UART_START;
          w_shift_next   = TX_DATA;
          w_bit_idx_next = '0;
        end
      end
      UART_START: begin
        if (w_bit_done) w_next = UART_DATA;
      end
      UART_DATA: begin
        if (w_bit_done) begin
          w_shift_next   = {1'b0, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == C_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            w_next = UART_PARITY;
`else
            w_next = UART_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_PARITY: begin
        if (w_bit_done) w_next = UART_STOP;
      end
`endif
      UART_STOP: begin
        if (w_bit_done) w_next = UART_IDLE;
      end
      default: w_next = UART_IDLE;
    endcase
  end

  // Line level is decoded from the upcoming state so it registers in step with it
  always_comb begin
    w_txd_next = 1'b1;
    case (w_next)
      UART_START:  w_txd_next = 1'b0;
      UART_DATA:   w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      UART_PARITY: w_txd_next = r_parity;
`endif
      default:     w_txd_next = 1'b1;
    endcase
  end

  assign UART_TXD = r_txd;
  assign TX_READY = r_ready;
  assign TX_BUSY  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx : self-checking bench for uart_tx at 10 clocks per bit    |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_uart_tx;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11 * CPB;
`else
  localparam int F = 10 * CPB;
`endif

  logic       FPGA_CLK = 1'b0;
  logic       RST_N    = 1'b0;
  logic [7:0] TX_DATA  = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY;
  logic       UART_TXD;
  logic       TX_BUSY;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx #(
    .CLK_FREQ(1000),
    .BAUD    (100)
  ) dut (
    .FPGA_CLK(FPGA_CLK),
    .RST_N   (RST_N),
    .TX_DATA (TX_DATA),
    .TX_VALID(TX_VALID),
    .TX_READY(TX_READY),
    .UART_TXD(UART_TXD),
    .TX_BUSY (TX_BUSY)
  );

  always #5 FPGA_CLK = ~FPGA_CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [7:0] data;
    bit         keep;
    logic [7:0] next;
    logic       exp_par;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference line waveform: cycle k of the frame (k=1..F) carries slot (k-1)/CPB
  function automatic logic [127:0] model_line(input logic [7:0] b);
    logic [127:0] e;
    bit           slots[$];
    e = '0;
    slots.push_back(1'b0);
    for (int i = 0; i < 8; i++) slots.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    slots.push_back(^b);
`endif
    slots.push_back(1'b1);
    for (int k = 1; k <= F; k++) e[k] = slots[(k-1)/CPB];
    e[F+1] = 1'b1;
    return e;
  endfunction

  task automatic start_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    TX_DATA  = b;
    TX_VALID = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if (TX_READY === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge FPGA_CLK);
    end
    chk("accept", 128'(ok), 128'(1));
    if (ok) @(posedge FPGA_CLK);
  endtask

  // Called right after the accepting edge; samples cycles 1..F+1 on negedges
  task automatic capture(input string name, input logic [7:0] b, input bit keep,
                         input logic [7:0] nb, input bit glitch, input logic exp_par);
    logic [127:0] a_txd, a_rdy, a_bsy, e_rdy, e_bsy;
    logic [7:0]   dec;
    a_txd = '0; a_rdy = '0; a_bsy = '0; e_rdy = '0; e_bsy = '0;
    for (int k = 1; k <= F + 1; k++) begin
      @(negedge FPGA_CLK);
      a_txd[k] = UART_TXD;
      a_rdy[k] = TX_READY;
      a_bsy[k] = TX_BUSY;
      e_rdy[k] = (k == F + 1);
      e_bsy[k] = (k != F + 1);
      if (k == 1) begin
        TX_VALID = keep;
        TX_DATA  = keep ? nb : 8'h3C;
      end
      if (glitch && k == 35) begin
        TX_VALID = 1'b1;
        TX_DATA  = 8'hFF;
      end
      if (glitch && k == 36) begin
        TX_VALID = 1'b0;
        TX_DATA  = 8'hAA;
      end
    end
    for (int i = 0; i < 8; i++) dec[i] = a_txd[(i+1)*CPB + CPB/2 + 1];
    chk({name, " line"},  a_txd, model_line(b));
    chk({name, " ready"}, a_rdy, e_rdy);
    chk({name, " busy"},  a_bsy, e_bsy);
    chk({name, " decode"}, 128'(dec), 128'(b));
`ifdef UART_TX_PARITY_EN
    chk({name, " parity"}, 128'(a_txd[9*CPB + CPB/2 + 1]), 128'(exp_par));
`else
    if (exp_par !== 1'bx) chk({name, " stop"}, 128'(a_txd[9*CPB + CPB/2 + 1]), 128'(1));
`endif
  endtask

  vec_t vecs[5];

  initial begin
    int         bad;
    bit         prev_keep;
    bit         keep;
    logic [7:0] cur, nb;

    vecs[0] = '{"x55",  8'h55, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{"xA3",  8'hA3, 1'b1, 8'h0F, 1'b0};
    vecs[2] = '{"x0F",  8'h0F, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{"x07",  8'h07, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{"x03",  8'h03, 1'b0, 8'h00, 1'b0};

    repeat (3) @(negedge FPGA_CLK);
    chk("reset txd",   128'(UART_TXD), 128'(1));
    chk("reset ready", 128'(TX_READY), 128'(1));
    chk("reset busy",  128'(TX_BUSY),  128'(0));
    RST_N = 1'b1;

    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge FPGA_CLK);
      if (UART_TXD !== 1'b1 || TX_READY !== 1'b1 || TX_BUSY !== 1'b0) bad++;
    end
    chk("idle 50 cycles bad count", 128'(bad), 128'(0));

    prev_keep = 0;
    for (int i = 0; i < 5; i++) begin
      if (!prev_keep) start_byte(vecs[i].data);
      capture(vecs[i].name, vecs[i].data, vecs[i].keep, vecs[i].next, 1'b0, vecs[i].exp_par);
      prev_keep = vecs[i].keep;
    end

    // Busy-time valid pulse and data toggling must not disturb the frame
    @(negedge FPGA_CLK);
    start_byte(8'h00);
    capture("glitch", 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge FPGA_CLK);
      if (UART_TXD !== 1'b1 || TX_READY !== 1'b1) bad++;
    end
    chk("no frame after glitch", 128'(bad), 128'(0));

    // Asynchronous reset in the middle of data bit 3
    start_byte(8'h00);
    for (int k = 1; k <= 45; k++) begin
      @(negedge FPGA_CLK);
      if (k == 1) TX_VALID = 1'b0;
    end
    chk("pre-reset txd",   128'(UART_TXD), 128'(0));
    chk("pre-reset ready", 128'(TX_READY), 128'(0));
    #2 RST_N = 1'b0;
    #1;
    chk("async reset txd",   128'(UART_TXD), 128'(1));
    chk("async reset ready", 128'(TX_READY), 128'(1));
    chk("async reset busy",  128'(TX_BUSY),  128'(0));
    repeat (2) @(negedge FPGA_CLK);
    RST_N = 1'b1;
    @(negedge FPGA_CLK);
    start_byte(8'h81);
    capture("x81 after reset", 8'h81, 1'b0, 8'h00, 1'b0, 1'b0);

    // Random bytes, random gaps and random back-to-back holds
    prev_keep = 0;
    cur = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      nb   = 8'($urandom);
      keep = (i < 9) && ($urandom_range(0, 1) == 1);
      if (!prev_keep) begin
        repeat ($urandom_range(0, 3)) @(negedge FPGA_CLK);
        start_byte(cur);
      end
      capture($sformatf("rand%0d_%h", i, cur), cur, keep, nb, 1'b0, ^cur);
      prev_keep = keep;
      cur = nb;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
